// File: rtl/mem_arbiter_if.sv
// Block-transfer port: level-held read/write request with a one-cycle ready pulse.
// The requester uses the master modport; the responder uses the slave modport.
interface mem_arbiter_if #(
   parameter int AW = 28,
   parameter int DW = 128
);
   logic          read;
   logic          write;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          ready;

   modport master (output read, write, addr, wdata, input rdata, ready);
   modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// Two-client arbiter for one slow_memory block port, with per-client wait-cycle counters.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the D-side wins every tie.
module mem_arbiter #(
   parameter int AW = 28,
   parameter int DW = 128,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  client_i,
   mem_arbiter_if.slave  client_d,
   mem_arbiter_if.master mem,
   output logic [CW-1:0] wait_I,
   output logic [CW-1:0] wait_D
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;

   state_t        state_reg, state_next;
   logic          req_i, req_d;
   logic          tie_to_i;
   logic [CW-1:0] wait_i_reg, wait_d_reg;

   assign req_i = client_i.read | client_i.write;
   assign req_d = client_d.read | client_d.write;

`ifdef ARB_RR_EN
   // last_grant_reg = 1 means D was granted most recently
   logic last_grant_reg, last_grant_next;

   assign tie_to_i = last_grant_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_reg <= 1'b1;
      end else begin
         last_grant_reg <= last_grant_next;
      end
   end

   always_comb begin
      last_grant_next = last_grant_reg;
      if (state_reg == IDLE && state_next == GNT_I) begin
         last_grant_next = 1'b0;
      end else if (state_reg == IDLE && state_next == GNT_D) begin
         last_grant_next = 1'b1;
      end
   end
`else
   assign tie_to_i = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (req_i && req_d) begin
               state_next = tie_to_i ? GNT_I : GNT_D;
            end else if (req_i) begin
               state_next = GNT_I;
            end else if (req_d) begin
               state_next = GNT_D;
            end
         end
         GNT_I: if (mem.ready) state_next = DRAIN;
         GNT_D: if (mem.ready) state_next = DRAIN;
         DRAIN: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory request mux: only the granted client reaches slow_memory
   always_comb begin
      mem.read  = 1'b0;
      mem.write = 1'b0;
      mem.addr  = '0;
      mem.wdata = '0;
      case (state_reg)
         GNT_I: begin
            mem.read  = client_i.read;
            mem.write = client_i.write;
            mem.addr  = client_i.addr;
            mem.wdata = client_i.wdata;
         end
         GNT_D: begin
            mem.read  = client_d.read;
            mem.write = client_d.write;
            mem.addr  = client_d.addr;
            mem.wdata = client_d.wdata;
         end
         default: ;
      endcase
   end

   assign client_i.ready = mem.ready && (state_reg == GNT_I);
   assign client_d.ready = mem.ready && (state_reg == GNT_D);
   assign client_i.rdata = mem.rdata;
   assign client_d.rdata = mem.rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_i_reg <= '0;
         wait_d_reg <= '0;
      end else begin
         if (req_i && state_reg != GNT_I) wait_i_reg <= wait_i_reg + CW'(1);
         if (req_d && state_reg != GNT_D) wait_d_reg <= wait_d_reg + CW'(1);
      end
   end

   assign wait_I = wait_i_reg;
   assign wait_D = wait_d_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single transfer, ties, spurious ready, mid-transfer reset, counter wrap.
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] wait_I, wait_D;
   int            checks   = 0;
   int            failures = 0;

   mem_arbiter_if #(.AW(AW), .DW(DW)) if_i ();
   mem_arbiter_if #(.AW(AW), .DW(DW)) if_d ();
   mem_arbiter_if #(.AW(AW), .DW(DW)) if_m ();

   mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .client_i (if_i),
      .client_d (if_d),
      .mem      (if_m),
      .wait_I   (wait_I),
      .wait_D   (wait_D)
   );

   always #5 clk = ~clk;

   localparam logic [DW-1:0] BLK_A  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [DW-1:0] BLK_B  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [DW-1:0] WDAT_D = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
`ifdef ARB_RR_EN
   localparam int BASE_WI = 1;
   localparam int BASE_WD = 4;
`else
   localparam int BASE_WI = 7;
   localparam int BASE_WD = 1;
`endif

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-18s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      if_i.read = 0; if_i.write = 0; if_i.addr = '0; if_i.wdata = '0;
      if_d.read = 0; if_d.write = 0; if_d.addr = '0; if_d.wdata = '0;
      if_m.rdata = '0; if_m.ready = 0;
      tick; tick;
      rst = 1'b0;
      chk("rst_mem_read", DW'(if_m.read), 0);
      chk("rst_wait_I", DW'(wait_I), 0);
      chk("rst_wait_D", DW'(wait_D), 0);

      // ---- single I read, memory ready on the 8th grant cycle
      if_i.read = 1; if_i.addr = 28'h0000010;
      tick;
      chk("t1_mem_read", DW'(if_m.read), 1);
      chk("t1_mem_addr", DW'(if_m.addr), 28'h0000010);
      chk("t1_wait_I", DW'(wait_I), 1);
      for (int k = 0; k < 7; k++) begin
         chk("t1_no_ready_I", DW'(if_i.ready), 0);
         tick;
      end
      if_m.ready = 1; if_m.rdata = BLK_A; settle;
      chk("t1_ready_I", DW'(if_i.ready), 1);
      chk("t1_rdata_I", if_i.rdata, BLK_A);
      chk("t1_ready_D", DW'(if_d.ready), 0);
      tick;
      if_m.ready = 0; if_i.read = 0; settle;
      chk("t1_drain_read", DW'(if_m.read), 0);
      chk("t1_drain_ready", DW'(if_i.ready), 0);
      tick;
      chk("t1_wait_I_end", DW'(wait_I), 1);
      chk("t1_wait_D_end", DW'(wait_D), 0);

      // ---- simultaneous requests from fresh reset
      rst = 1; tick; rst = 0;
      if_i.read = 1; if_i.addr = 28'h0000010;
      if_d.write = 1; if_d.addr = 28'h0000020; if_d.wdata = WDAT_D;
      tick;
`ifdef ARB_RR_EN
      chk("t2_first_I_read", DW'(if_m.read), 1);
      chk("t2_first_I_addr", DW'(if_m.addr), 28'h0000010);
      if_m.ready = 1; if_m.rdata = BLK_B; settle;
      chk("t2_ready_I", DW'(if_i.ready), 1);
      tick; if_m.ready = 0; if_i.read = 0; settle;
      chk("t2_drain", DW'(if_m.write | if_m.read), 0);
      tick; tick;
      chk("t2_D_write", DW'(if_m.write), 1);
      chk("t2_D_wdata", if_m.wdata, WDAT_D);
      chk("t2_wait_D", DW'(wait_D), 4);
      if_m.ready = 1; settle;
      chk("t2_ready_D", DW'(if_d.ready), 1);
      tick; if_m.ready = 0; if_d.write = 0;
      tick;
`else
      chk("t2_D_write", DW'(if_m.write), 1);
      chk("t2_D_noread", DW'(if_m.read), 0);
      chk("t2_D_addr", DW'(if_m.addr), 28'h0000020);
      chk("t2_D_wdata", if_m.wdata, WDAT_D);
      tick; tick; tick;
      if_m.ready = 1; settle;
      chk("t2_ready_D", DW'(if_d.ready), 1);
      chk("t2_ready_I_low", DW'(if_i.ready), 0);
      tick; if_m.ready = 0; if_d.write = 0; settle;
      chk("t2_drain", DW'(if_m.write | if_m.read), 0);
      tick;
      chk("t2_idle", DW'(if_m.read), 0);
      tick;
      chk("t2_I_read", DW'(if_m.read), 1);
      chk("t2_I_addr", DW'(if_m.addr), 28'h0000010);
      chk("t2_wait_I", DW'(wait_I), 7);
      chk("t2_wait_D", DW'(wait_D), 1);
      if_m.ready = 1; if_m.rdata = BLK_B; settle;
      chk("t2_ready_I", DW'(if_i.ready), 1);
      tick; if_m.ready = 0; if_i.read = 0;
      tick;
`endif

      // ---- spurious ready in IDLE, stray ready in DRAIN
      if_m.ready = 1; settle;
      chk("t3_idle_ready_I", DW'(if_i.ready), 0);
      chk("t3_idle_ready_D", DW'(if_d.ready), 0);
      tick; if_m.ready = 0; settle;
      chk("t3_idle_stays", DW'(if_m.read), 0);
      if_d.read = 1; if_d.addr = 28'h0000030;
      tick;
      chk("t3_D_read", DW'(if_m.read), 1);
      if_m.ready = 1; settle;
      chk("t3_ready_D", DW'(if_d.ready), 1);
      tick; if_d.read = 0; settle;
      chk("t3_drain_ready_D", DW'(if_d.ready), 0);
      chk("t3_drain_ready_I", DW'(if_i.ready), 0);
      chk("t3_drain_read", DW'(if_m.read), 0);
      tick; if_m.ready = 0; settle;
      chk("t3_back_idle", DW'(if_m.read), 0);

      // ---- reset during GNT_D
      if_d.read = 1; if_d.addr = 28'h0000030;
      tick;
      chk("t4_D_grant", DW'(if_m.read), 1);
      if_i.read = 1;
      tick; tick; tick;
      chk("t4_wait_I_pre", DW'(wait_I), BASE_WI + 3);
      chk("t4_wait_D_pre", DW'(wait_D), BASE_WD + 2);
      rst = 1;
      tick;
      chk("t4_rst_read", DW'(if_m.read), 0);
      chk("t4_rst_addr", DW'(if_m.addr), 0);
      chk("t4_rst_wait_I", DW'(wait_I), 0);
      chk("t4_rst_wait_D", DW'(wait_D), 0);
      if_m.ready = 1; settle;
      chk("t4_rst_no_ready", DW'(if_d.ready), 0);
      rst = 0; if_m.ready = 0; if_i.read = 0; if_d.addr = 28'h0000040;
      tick;
      chk("t4_new_read", DW'(if_m.read), 1);
      chk("t4_new_addr", DW'(if_m.addr), 28'h0000040);
      chk("t4_new_wait_D", DW'(wait_D), 1);
      if_m.ready = 1; if_m.rdata = BLK_A; settle;
      chk("t4_new_ready", DW'(if_d.ready), 1);
      chk("t4_new_rdata", if_d.rdata, BLK_A);
      tick; if_m.ready = 0; if_d.read = 0;
      tick;

      // ---- wait counter wrap with CW = 4
      rst = 1; tick; rst = 0;
      if_d.read = 1;
      tick;
      if_i.read = 1;
      for (int k = 0; k < 15; k++) tick;
      chk("t5_wait_I_max", DW'(wait_I), 15);
      tick;
      chk("t5_wait_I_wrap", DW'(wait_I), 0);
      if_m.ready = 1; settle;
      chk("t5_ready_D", DW'(if_d.ready), 1);
      tick; if_m.ready = 0; if_d.read = 0;
      tick; tick;
      chk("t5_I_granted", DW'(if_m.read), 1);
      if_m.ready = 1; tick; if_m.ready = 0; if_i.read = 0;
      tick;

`ifdef ARB_RR_EN
      // ---- round-robin fairness over six back-to-back ties
      rst = 1; tick; rst = 0;
      if_i.read = 1; if_i.addr = 28'h0000100;
      if_d.read = 1; if_d.addr = 28'h0000200;
      tick;
      for (int n = 0; n < 6; n++) begin
         chk("t6_grant_addr", DW'(if_m.addr), (n % 2 == 0) ? 28'h0000100 : 28'h0000200);
         if_m.ready = 1;
         tick; if_m.ready = 0; settle;
         chk("t6_drain", DW'(if_m.read | if_m.write), 0);
         tick; tick;
      end
      if_i.read = 0; if_d.read = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
